var_assign_ctrl: RTL
====================

VAR_ASSIGN_CTRL -- requirements
Module: var_assign_ctrl

Interface
REQ-001 Parameter NAME_W, default 6, sets the variable-table index width.
REQ-002 Parameter DATA_W, default 32, sets the value-handle width.
REQ-003 Parameter EXP_TIMEOUT, default 255, is the maximum number of cycles to wait for an expander response.
REQ-004 Ports SHALL be:
- clk  in  1  clock; one clock only
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  assignment command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  3  0 EQ (=), 1 COLON_EQ (:=), 2 QUESTION_EQ (?=), 3 PLUS_EQ (+=), 4-7 illegal
- cmd_name  in  NAME_W  variable index
- cmd_value  in  DATA_W  raw value handle
- tbl_rd_en  out  1  defined-bit lookup strobe
- tbl_rd_addr  out  NAME_W  lookup index
- tbl_rd_defined  in  1  lookup result, valid the cycle after tbl_rd_en
- tbl_wr_en  out  1  table write strobe
- tbl_wr_addr  out  NAME_W  write index
- tbl_wr_data  out  DATA_W  value written
- tbl_wr_append  out  1  1: append with space separator; 0: overwrite
- exp_req_valid / exp_req_ready  out / in  1  expander request handshake
- exp_req_data  out  DATA_W  raw value to expand
- exp_rsp_valid  in  1  expanded value valid, single-cycle pulse
- exp_rsp_data  in  DATA_W  expanded value
- done_valid  out  1  one-cycle completion pulse
- done_status  out  2  0 WRITTEN, 1 SKIPPED, 2 BAD_OP, 3 TIMEOUT
- busy  out  1  high in every state except IDLE

Function
REQ-005 States SHALL be IDLE, LOOKUP, CHECK, EXP_REQ, EXP_WAIT, WRITE, DONE.
REQ-006 cmd_ready SHALL equal (state==IDLE); on accept, op/name/value are latched and inputs are ignored until return to IDLE.
REQ-007 EQ: IDLE->WRITE; overwrite with the raw value; no lookup, no expansion.
REQ-008 COLON_EQ: IDLE->EXP_REQ; overwrite with the expanded value.
REQ-009 QUESTION_EQ: IDLE->LOOKUP->CHECK; if defined, go to DONE with SKIPPED and no expansion or write; else go to EXP_REQ and overwrite with the expanded value.
REQ-010 PLUS_EQ: IDLE->LOOKUP->CHECK->EXP_REQ; write the expanded value with tbl_wr_append = defined bit sampled in CHECK.
REQ-011 Illegal op: IDLE->DONE with BAD_OP; no table or expander activity.
REQ-012 LOOKUP asserts tbl_rd_en for exactly one cycle; CHECK samples tbl_rd_defined.
REQ-013 EXP_REQ holds exp_req_valid and stable exp_req_data until exp_req_ready; the handshake moves to EXP_WAIT.
REQ-014 In EXP_WAIT a timer counts from 1 in the first cycle; exp_rsp_valid captures exp_rsp_data and moves to WRITE; reaching EXP_TIMEOUT without a response moves to DONE with TIMEOUT and no write.
REQ-015 If exp_rsp_valid coincides with the timeout cycle, the response SHALL win.
REQ-016 exp_rsp_valid outside EXP_WAIT SHALL be ignored.
REQ-017 WRITE asserts tbl_wr_en for exactly one cycle, with done_valid=1 and done_status=WRITTEN in that same cycle, then returns to IDLE.
REQ-018 DONE asserts done_valid for one cycle with the latched status, then returns to IDLE.
REQ-019 Latency from accept to done_valid: EQ 1 cycle; QUESTION_EQ skip 3 cycles; illegal op 1 cycle; expanding ops 2 cycles (+2 for LOOKUP/CHECK) + ready wait + response wait + 1.
REQ-020 All strobes SHALL be single-cycle; no output other than registered state is driven in IDLE.

Reset
REQ-021 rst SHALL asynchronously force IDLE, clear the timer and latched command, and drive all outputs to 0 except cmd_ready=1.
REQ-022 Reset mid-operation SHALL abandon the command with no tbl_wr_en and no done_valid; a post-reset response is ignored.

Structure
REQ-023 Op codes, status codes and the state enum SHALL reside in shared package vamk_pkg.
REQ-024 The EXP_WAIT timeout counter SHALL be sub-module exp_timer (clear, enable, expired).

Verification
REQ-025 EQ name=5 value=0xA5 -> next cycle tbl_wr_en, addr 5, data 0xA5, append 0, done WRITTEN; exp_req_valid never asserted.
REQ-026 QUESTION_EQ name=3 with defined=1 -> one tbl_rd_en, done SKIPPED 3 cycles after accept, no exp_req_valid, no write; with defined=0 and response 0x77 -> write 0x77, append 0.
REQ-027 PLUS_EQ name=9 with defined=1, exp_req_ready delayed 4 cycles, response 0x1234 -> write 0x1234 with append 1; with defined=0 -> append 0.
REQ-028 COLON_EQ with no response, EXP_TIMEOUT=8 -> done TIMEOUT in the 8th EXP_WAIT cycle, no write; response in that same cycle -> WRITTEN instead.
REQ-029 cmd_op=6 -> done BAD_OP one cycle after accept; rst pulsed during EXP_WAIT -> no write, no done, cmd_ready=1 immediately.

Source files
------------

// File: rtl/vamk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vamk_pkg
// Purpose  : Shared definitions for the variable-assignment controller.
//            Holds the assignment operator encodings, the completion status
//            codes and the controller state enumeration.
// Contents : op_e     - cmd_op encodings (values 4..7 are illegal)
//            status_e - done_status encodings
//            state_e  - controller FSM states
// Revision : 1.0 - initial release
// ============================================================================
package vamk_pkg;

   // Assignment operators carried on cmd_op.
   typedef enum logic [2:0] {
      OP_EQ          = 3'd0,   // =   overwrite with raw value
      OP_COLON_EQ    = 3'd1,   // :=  overwrite with expanded value
      OP_QUESTION_EQ = 3'd2,   // ?=  assign expanded value only if undefined
      OP_PLUS_EQ     = 3'd3    // +=  append expanded value if already defined
   } op_e;

   // Completion status reported with done_valid.
   typedef enum logic [1:0] {
      STATUS_WRITTEN = 2'd0,
      STATUS_SKIPPED = 2'd1,
      STATUS_BAD_OP  = 2'd2,
      STATUS_TIMEOUT = 2'd3
   } status_e;

   // Controller states.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_CHECK    = 3'd2,
      S_EXP_REQ  = 3'd3,
      S_EXP_WAIT = 3'd4,
      S_WRITE    = 3'd5,
      S_DONE     = 3'd6
   } state_e;

endpackage : vamk_pkg
`default_nettype wire

// File: rtl/exp_timer.sv
`default_nettype none
// ============================================================================
// Module   : exp_timer
// Purpose  : Expander response timeout counter. While enable is high the
//            counter advances once per cycle; expired is asserted in the
//            LIMIT-th enabled cycle (the first enabled cycle counts as 1).
//            clear has priority and returns the counter to zero.
// Ports    : clk     in  clock
//            rst     in  asynchronous active-high reset
//            clear   in  synchronous clear of the count
//            enable  in  count this cycle
//            expired out high in the LIMIT-th consecutive enabled cycle
// Params   : LIMIT   cycle count that expires the timer (must be >= 1)
// Revision : 1.0 - initial release
// ============================================================================
module exp_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // count_q holds the number of already completed enabled cycles, so the
   // cycle currently in progress is count_q+1. It never needs to reach LIMIT.
   localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      expired = enable && (count_q == LAST_CNT);
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : exp_timer
`default_nettype wire

// File: rtl/var_assign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : var_assign_ctrl
// Purpose  : Executes one variable-assignment command at a time against an
//            external variable table and value expander. Supports =, :=, ?=
//            and +=, reporting each command's outcome with a done pulse.
// Ports    : clk, rst                       clock, async active-high reset
//            cmd_valid/cmd_ready            command handshake
//            cmd_op/cmd_name/cmd_value      operator, table index, raw value
//            tbl_rd_en/tbl_rd_addr          defined-bit lookup strobe/index
//            tbl_rd_defined                 lookup result (cycle after strobe)
//            tbl_wr_en/addr/data/append     table write strobe and payload
//            exp_req_valid/ready/data       expander request handshake
//            exp_rsp_valid/exp_rsp_data     expander response pulse
//            done_valid/done_status         completion pulse and status
//            busy                           high whenever not idle
// Params   : NAME_W, DATA_W, EXP_TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module var_assign_ctrl
   import vamk_pkg::*;
#(
   parameter int unsigned NAME_W      = 6,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned EXP_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [NAME_W-1:0] cmd_name,
   input  logic [DATA_W-1:0] cmd_value,
   output logic              tbl_rd_en,
   output logic [NAME_W-1:0] tbl_rd_addr,
   input  logic              tbl_rd_defined,
   output logic              tbl_wr_en,
   output logic [NAME_W-1:0] tbl_wr_addr,
   output logic [DATA_W-1:0] tbl_wr_data,
   output logic              tbl_wr_append,
   output logic              exp_req_valid,
   input  logic              exp_req_ready,
   output logic [DATA_W-1:0] exp_req_data,
   input  logic              exp_rsp_valid,
   input  logic [DATA_W-1:0] exp_rsp_data,
   output logic              done_valid,
   output logic [1:0]        done_status,
   output logic              busy
);

   state_e            state_q,   state_d;
   logic [2:0]        op_q,      op_d;
   logic [NAME_W-1:0] name_q,    name_d;
   // Holds the raw value until the expander answers, then the expanded value.
   logic [DATA_W-1:0] value_q,   value_d;
   logic              defined_q, defined_d;
   status_e           status_q,  status_d;

   logic              timer_clear;
   logic              timer_en;
   logic              timer_expired;

   assign timer_en    = (state_q == S_EXP_WAIT);
   assign timer_clear = (state_q != S_EXP_WAIT);

   exp_timer #(
      .LIMIT   (EXP_TIMEOUT)
   ) u_exp_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         name_q    <= '0;
         value_q   <= '0;
         defined_q <= 1'b0;
         status_q  <= STATUS_WRITTEN;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         name_q    <= name_d;
         value_q   <= value_d;
         defined_q <= defined_d;
         status_q  <= status_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      name_d        = name_q;
      value_d       = value_q;
      defined_d     = defined_q;
      status_d      = status_q;

      // Every output is gated by state so nothing but cmd_ready is driven
      // while idle or in reset.
      cmd_ready     = 1'b0;
      tbl_rd_en     = 1'b0;
      tbl_rd_addr   = '0;
      tbl_wr_en     = 1'b0;
      tbl_wr_addr   = '0;
      tbl_wr_data   = '0;
      tbl_wr_append = 1'b0;
      exp_req_valid = 1'b0;
      exp_req_data  = '0;
      done_valid    = 1'b0;
      done_status   = STATUS_WRITTEN;
      busy          = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d      = cmd_op;
               name_d    = cmd_name;
               value_d   = cmd_value;
               defined_d = 1'b0;
               status_d  = STATUS_WRITTEN;
               case (cmd_op)
                  OP_EQ:          state_d = S_WRITE;
                  OP_COLON_EQ:    state_d = S_EXP_REQ;
                  OP_QUESTION_EQ: state_d = S_LOOKUP;
                  OP_PLUS_EQ:     state_d = S_LOOKUP;
                  default: begin
                     status_d = STATUS_BAD_OP;
                     state_d  = S_DONE;
                  end
               endcase
            end
         end

         S_LOOKUP: begin
            tbl_rd_en   = 1'b1;
            tbl_rd_addr = name_q;
            state_d     = S_CHECK;
         end

         S_CHECK: begin
            defined_d = tbl_rd_defined;
            if ((op_q == OP_QUESTION_EQ) && tbl_rd_defined) begin
               status_d = STATUS_SKIPPED;
               state_d  = S_DONE;
            end else begin
               state_d  = S_EXP_REQ;
            end
         end

         S_EXP_REQ: begin
            exp_req_valid = 1'b1;
            exp_req_data  = value_q;
            if (exp_req_ready) begin
               state_d = S_EXP_WAIT;
            end
         end

         S_EXP_WAIT: begin
            // A response landing in the expiry cycle still wins.
            if (exp_rsp_valid) begin
               value_d = exp_rsp_data;
               state_d = S_WRITE;
            end else if (timer_expired) begin
               status_d = STATUS_TIMEOUT;
               state_d  = S_DONE;
            end
         end

         S_WRITE: begin
            tbl_wr_en     = 1'b1;
            tbl_wr_addr   = name_q;
            tbl_wr_data   = value_q;
            // Only += appends, and only onto an already defined variable;
            // defined_q stays 0 for ops that never pass through CHECK.
            tbl_wr_append = defined_q && (op_q == OP_PLUS_EQ);
            done_valid    = 1'b1;
            done_status   = STATUS_WRITTEN;
            state_d       = S_IDLE;
         end

         S_DONE: begin
            done_valid  = 1'b1;
            done_status = status_q;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule : var_assign_ctrl
`default_nettype wire
